rr_encoder_32to5: RTL and testbench



---
 rtl/rr_enc_pkg.sv | 10 +
 rtl/rr_pick32.sv | 30 +++
 rtl/rr_encoder_32to5.sv | 74 +++++++
 tb/tb_rr_encoder_32to5.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_enc_pkg.sv
// Shared sizes and types for the 32:5 round-robin encoder.
package rr_enc_pkg;
  localparam int N     = 32;
  localparam int IDX_W = 5;
  localparam int CNT_W = 6;

  typedef logic [N-1:0]     req_vec_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/rr_pick32.sv
// Combinational round-robin picker: first set bit of pend at or after ptr, wrapping.
module rr_pick32
  import rr_enc_pkg::*;
(
  input  logic [31:0] pend,
  input  logic [4:0]  ptr,
  output logic [4:0]  sel,
  output logic        any
);
  req_vec_t w_rot;
  idx_t     w_enc;

  // Bit gi of the rotated vector is the line gi positions after ptr (5-bit wrap).
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      assign w_rot[gi] = pend[IDX_W'(gi) + ptr];
    end
  endgenerate

  always_comb begin
    w_enc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_enc = IDX_W'(i);
    end
  end

  assign any = |w_rot;
  assign sel = w_enc + ptr;
endmodule

// File: rtl/rr_encoder_32to5.sv
// Round-robin 32:5 encoder: collects pending request lines and issues indices over valid/ready.
module rr_encoder_32to5
  import rr_enc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] set_i,
  input  logic        clr_all,
  output logic [4:0]  idx_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] pend_o,
  output logic [5:0]  count_o
);
  req_vec_t r_pend;
  idx_t     r_ptr;
  idx_t     r_idx;
  logic     r_valid;

  idx_t     w_sel;
  logic     w_any;
  logic     w_load;
  logic     w_issue;
  req_vec_t w_issue_mask;
  cnt_t     w_count;

  rr_pick32 u_pick (
    .pend (r_pend),
    .ptr  (r_ptr),
    .sel  (w_sel),
    .any  (w_any)
  );

  assign w_load       = !r_valid || ready_i;
  assign w_issue      = w_load && w_any;
  assign w_issue_mask = w_issue ? (req_vec_t'(1) << w_sel) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend  <= '0;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (clr_all) begin
      r_pend  <= '0;
      r_ptr   <= '0;
      r_valid <= 1'b0;
    end else begin
      // A same-cycle set re-pends a line that is being issued right now.
      r_pend <= (r_pend & ~w_issue_mask) | set_i;
      if (w_load) begin
        if (w_any) begin
          r_idx   <= w_sel;
          r_valid <= 1'b1;
          r_ptr   <= w_sel + IDX_W'(1);
        end else begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < N; i++) begin
      w_count = w_count + CNT_W'(r_pend[i]);
    end
  end

  assign idx_o   = r_idx;
  assign valid_o = r_valid;
  assign pend_o  = r_pend;
  assign count_o = w_count;
endmodule

// File: tb/tb_rr_encoder_32to5.sv
// Directed self-checking bench for rr_encoder_32to5.
module tb_rr_encoder_32to5;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] set_i;
  logic        clr_all;
  logic [4:0]  idx_o;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] pend_o;
  logic [5:0]  count_o;

  int checks = 0;
  int errors = 0;

  rr_encoder_32to5 dut (
    .clk     (clk),
    .reset   (reset),
    .set_i   (set_i),
    .clr_all (clr_all),
    .idx_o   (idx_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .pend_o  (pend_o),
    .count_o (count_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    clr_all = 1'b1; set_i = '0;
    step();
    clr_all = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; set_i = '0; clr_all = 1'b0; ready_i = 1'b0;
    step(); step();
    checks++;
    if (valid_o !== 1'b0 || idx_o !== 5'd0 || pend_o !== 32'd0 || count_o !== 6'd0) begin
      errors++;
      $display("FAIL reset: valid=%b idx=%0d pend=%h count=%0d, required 0 0 0 0", valid_o, idx_o, pend_o, count_o);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    set_i = 32'h1; ready_i = 1'b1;
    step();
    set_i = '0;
    checks++;
    if (valid_o !== 1'b0 || pend_o !== 32'h1 || count_o !== 6'd1) begin
      errors++;
      $display("FAIL single_pend: valid=%b pend=%h count=%0d, required 0 1 1", valid_o, pend_o, count_o);
    end
    step();
    checks++;
    if (valid_o !== 1'b1 || idx_o !== 5'd0 || count_o !== 6'd0) begin
      errors++;
      $display("FAIL single_issue: valid=%b idx=%0d count=%0d, required 1 0 0", valid_o, idx_o, count_o);
    end
    step();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: valid=%b, required 0", valid_o);
    end
    $display("single: idx=%0d valid=%b", idx_o, valid_o);
  endtask

  task automatic test_wrap();
    logic [4:0] exp_seq [3];
    exp_seq[0] = 5'd0; exp_seq[1] = 5'd1; exp_seq[2] = 5'd31;
    flush();
    set_i = 32'h8000_0003; ready_i = 1'b1;
    step();
    set_i = '0;
    checks++;
    if (count_o !== 6'd3) begin
      errors++;
      $display("FAIL wrap_count: count=%0d, required 3", count_o);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (valid_o !== 1'b1 || idx_o !== exp_seq[k]) begin
        errors++;
        $display("FAIL wrap_seq%0d: valid=%b idx=%0d, required 1 %0d", k, valid_o, idx_o, exp_seq[k]);
      end
      $display("wrap: issue %0d idx=%0d", k, idx_o);
    end
    step();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL wrap_drain: valid=%b, required 0", valid_o);
    end
    // ptr wrapped to 0: line 0 must beat line 1 now.
    set_i = 32'h3;
    step();
    set_i = '0;
    step();
    checks++;
    if (valid_o !== 1'b1 || idx_o !== 5'd0) begin
      errors++;
      $display("FAIL wrap_ptr0: valid=%b idx=%0d, required 1 0", valid_o, idx_o);
    end
    step(); step();
  endtask

  task automatic test_rr_order();
    flush();
    ready_i = 1'b1;
    set_i = 32'h2;
    step();
    set_i = '0;
    step();
    checks++;
    if (idx_o !== 5'd1 || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL rr_first: valid=%b idx=%0d, required 1 1", valid_o, idx_o);
    end
    set_i = 32'h21;
    step();
    set_i = '0;
    step();
    checks++;
    if (idx_o !== 5'd5 || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL rr_5: valid=%b idx=%0d, required 1 5", valid_o, idx_o);
    end
    step();
    checks++;
    if (idx_o !== 5'd0 || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL rr_0: valid=%b idx=%0d, required 1 0", valid_o, idx_o);
    end
    $display("rr_order: last idx=%0d", idx_o);
    step();
  endtask

  task automatic test_stall();
    flush();
    ready_i = 1'b0;
    set_i = 32'h8;
    step();
    set_i = '0;
    step();
    set_i = 32'h80;
    for (int k = 0; k < 4; k++) begin
      step();
      set_i = '0;
      checks++;
      if (valid_o !== 1'b1 || idx_o !== 5'd3 || pend_o !== 32'h80) begin
        errors++;
        $display("FAIL stall%0d: valid=%b idx=%0d pend=%h, required 1 3 00000080", k, valid_o, idx_o, pend_o);
      end
    end
    ready_i = 1'b1;
    step();
    checks++;
    if (valid_o !== 1'b1 || idx_o !== 5'd7 || pend_o !== 32'h0) begin
      errors++;
      $display("FAIL stall_release: valid=%b idx=%0d pend=%h, required 1 7 0", valid_o, idx_o, pend_o);
    end
    $display("stall: released idx=%0d", idx_o);
    step();
  endtask

  task automatic test_back_to_back();
    flush();
    ready_i = 1'b1;
    set_i = 32'h10;
    step();
    step();
    set_i = '0;
    checks++;
    if (valid_o !== 1'b1 || idx_o !== 5'd4 || pend_o !== 32'h10) begin
      errors++;
      $display("FAIL repend: valid=%b idx=%0d pend=%h, required 1 4 00000010", valid_o, idx_o, pend_o);
    end
    step();
    checks++;
    if (valid_o !== 1'b1 || idx_o !== 5'd4 || pend_o !== 32'h0) begin
      errors++;
      $display("FAIL reissue: valid=%b idx=%0d pend=%h, required 1 4 0", valid_o, idx_o, pend_o);
    end
    $display("back_to_back: reissued idx=%0d", idx_o);
    step();
  endtask

  task automatic test_clear();
    flush();
    ready_i = 1'b0;
    set_i = 32'hF0;
    step();
    step();
    set_i = '0;
    checks++;
    if (valid_o !== 1'b1 || idx_o !== 5'd4 || pend_o !== 32'hF0 || count_o !== 6'd4) begin
      errors++;
      $display("FAIL clr_setup: valid=%b idx=%0d pend=%h count=%0d, required 1 4 000000f0 4", valid_o, idx_o, pend_o, count_o);
    end
    clr_all = 1'b1; set_i = 32'h1;
    step();
    clr_all = 1'b0; set_i = '0; ready_i = 1'b1;
    checks++;
    if (valid_o !== 1'b0 || pend_o !== 32'h0 || count_o !== 6'd0) begin
      errors++;
      $display("FAIL clr_all: valid=%b pend=%h count=%0d, required 0 0 0", valid_o, pend_o, count_o);
    end
    step();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL clr_after: valid=%b, required 0", valid_o);
    end
    $display("clear: pend=%h valid=%b", pend_o, valid_o);
  endtask

  task automatic test_async_reset();
    ready_i = 1'b0;
    set_i = 32'hF0;
    step();
    step();
    set_i = '0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (valid_o !== 1'b0 || idx_o !== 5'd0 || pend_o !== 32'h0 || count_o !== 6'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b idx=%0d pend=%h count=%0d, required 0 0 0 0", valid_o, idx_o, pend_o, count_o);
    end
    step();
    reset = 1'b0; set_i = 32'h1; ready_i = 1'b1;
    step();
    set_i = '0;
    checks++;
    if (valid_o !== 1'b0 || pend_o !== 32'h1) begin
      errors++;
      $display("FAIL post_reset_edge1: valid=%b pend=%h, required 0 00000001", valid_o, pend_o);
    end
    step();
    checks++;
    if (valid_o !== 1'b1 || idx_o !== 5'd0) begin
      errors++;
      $display("FAIL post_reset_edge2: valid=%b idx=%0d, required 1 0", valid_o, idx_o);
    end
    $display("async_reset: first issue idx=%0d", idx_o);
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_rr_order();
    test_stall();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
